// File: rtl/candy_vend_ctrl.sv
// rtl/candy_vend_ctrl.sv - candy machine vending FSM: coin credit, dispense timing, change and idle refund
module candy_vend_ctrl #(
    parameter int PRICE          = 65,
    parameter int DISPENSE_TICKS = 6,
    parameter int TIMEOUT_TICKS  = 20
) (
    input  logic       clk_100MHz,
    input  logic       reset_n,
    input  logic       clk_2Hz,
    input  logic       coin_nickel,
    input  logic       coin_dime,
    input  logic       coin_quarter,
    input  logic       cancel,
    output logic [7:0] credit,
    output logic       dispense,
    output logic       led_blink,
    output logic [7:0] change_cents,
    output logic       change_valid,
    output logic       coin_reject,
    output logic       busy
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CREDIT,
        ST_DISPENSE,
        ST_REFUND
    } state_t;

    localparam logic [8:0] PRICE_W   = 9'(PRICE);
    localparam logic [7:0] DISP_LAST = 8'(DISPENSE_TICKS - 1);
    localparam logic [7:0] TO_LAST   = 8'(TIMEOUT_TICKS - 1);

    state_t     state_q, state_d;
    logic [7:0] credit_q, credit_d;
    logic       dispense_q, dispense_d;
    logic       led_q, led_d;
    logic [7:0] change_q, change_d;
    logic       change_valid_q, change_valid_d;
    logic       coin_reject_q, coin_reject_d;
    logic       busy_q, busy_d;
    logic [7:0] tick_cnt_q, tick_cnt_d;
    logic [7:0] disp_cnt_q, disp_cnt_d;

    // clk_2Hz is data here: two sync stages, one history stage for edge detect,
    // and an arm shift so a level already high at reset release is not a rise
    logic       sync1_q, sync1_d, sync2_q, sync2_d, sync3_q, sync3_d;
    logic [2:0] arm_q, arm_d;
    logic       tick_q, tick_d;

    logic [7:0] coin_val;
    logic       coin_any;
    logic       lower_rej;
    logic [8:0] sum;
    logic [8:0] over;
    logic       go_dispense;
    logic       go_refund;

    // synchronizer and registered tick pulse, three cycles after the clk_2Hz rise
    always_comb begin
        sync1_d = clk_2Hz;
        sync2_d = sync1_q;
        sync3_d = sync2_q;
        arm_d   = {arm_q[1:0], 1'b1};
        tick_d  = sync2_q & ~sync3_q & arm_q[2];
    end

    // coin priority decode: quarter > dime > nickel, losers flagged for reject
    always_comb begin
        coin_val  = 8'd0;
        if (coin_quarter)     coin_val = 8'd25;
        else if (coin_dime)   coin_val = 8'd10;
        else if (coin_nickel) coin_val = 8'd5;
        coin_any  = coin_quarter | coin_dime | coin_nickel;
        lower_rej = (coin_quarter & (coin_dime | coin_nickel)) | (coin_dime & coin_nickel);
        sum       = {1'b0, credit_q} + {1'b0, coin_val};
        over      = sum - PRICE_W;
    end

    // next state and next registered outputs
    always_comb begin
        state_d        = state_q;
        credit_d       = credit_q;
        dispense_d     = dispense_q;
        led_d          = led_q;
        change_d       = change_q;
        change_valid_d = 1'b0;
        coin_reject_d  = 1'b0;
        busy_d         = busy_q;
        tick_cnt_d     = tick_cnt_q;
        disp_cnt_d     = disp_cnt_q;
        go_dispense    = 1'b0;
        go_refund      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                credit_d   = 8'd0;
                tick_cnt_d = 8'd0;
                if (coin_any) begin
                    coin_reject_d = lower_rej;
                    credit_d      = coin_val;
                    if (sum >= PRICE_W) go_dispense = 1'b1;
                    else                state_d     = ST_CREDIT;
                end
            end
            ST_CREDIT: begin
                if (cancel) begin
                    coin_reject_d = coin_any;
                    go_refund     = 1'b1;
                end else if (coin_any) begin
                    coin_reject_d = lower_rej;
                    tick_cnt_d    = 8'd0;
                    credit_d      = sum[7:0];
                    if (sum >= PRICE_W) go_dispense = 1'b1;
                end else if (tick_q) begin
                    if (tick_cnt_q == TO_LAST) go_refund  = 1'b1;
                    else                       tick_cnt_d = tick_cnt_q + 8'd1;
                end
            end
            ST_DISPENSE: begin
                coin_reject_d = coin_any;
                if (tick_q) begin
                    if (disp_cnt_q == DISP_LAST) begin
                        change_valid_d = 1'b1;
                        credit_d       = 8'd0;
                        dispense_d     = 1'b0;
                        led_d          = 1'b0;
                        busy_d         = 1'b0;
                        state_d        = ST_IDLE;
                    end else begin
                        led_d      = ~led_q;
                        disp_cnt_d = disp_cnt_q + 8'd1;
                    end
                end
            end
            ST_REFUND: begin
                coin_reject_d = coin_any;
                credit_d      = 8'd0;
                busy_d        = 1'b0;
                state_d       = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (go_dispense) begin
            change_d   = over[7:0];
            credit_d   = sum[7:0];
            disp_cnt_d = 8'd0;
            tick_cnt_d = 8'd0;
            dispense_d = 1'b1;
            led_d      = 1'b1;
            busy_d     = 1'b1;
            state_d    = ST_DISPENSE;
        end
        if (go_refund) begin
            change_d       = credit_q;
            credit_d       = 8'd0;
            change_valid_d = 1'b1;
            busy_d         = 1'b1;
            tick_cnt_d     = 8'd0;
            state_d        = ST_REFUND;
        end
    end

    // state, output and synchronizer registers
    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            credit_q       <= 8'd0;
            dispense_q     <= 1'b0;
            led_q          <= 1'b0;
            change_q       <= 8'd0;
            change_valid_q <= 1'b0;
            coin_reject_q  <= 1'b0;
            busy_q         <= 1'b0;
            tick_cnt_q     <= 8'd0;
            disp_cnt_q     <= 8'd0;
            sync1_q        <= 1'b0;
            sync2_q        <= 1'b0;
            sync3_q        <= 1'b0;
            arm_q          <= 3'd0;
            tick_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            credit_q       <= credit_d;
            dispense_q     <= dispense_d;
            led_q          <= led_d;
            change_q       <= change_d;
            change_valid_q <= change_valid_d;
            coin_reject_q  <= coin_reject_d;
            busy_q         <= busy_d;
            tick_cnt_q     <= tick_cnt_d;
            disp_cnt_q     <= disp_cnt_d;
            sync1_q        <= sync1_d;
            sync2_q        <= sync2_d;
            sync3_q        <= sync3_d;
            arm_q          <= arm_d;
            tick_q         <= tick_d;
        end
    end

    assign credit       = credit_q;
    assign dispense     = dispense_q;
    assign led_blink    = led_q;
    assign change_cents = change_q;
    assign change_valid = change_valid_q;
    assign coin_reject  = coin_reject_q;
    assign busy         = busy_q;

endmodule
